// File: rtl/hazard_scoreboard_if.sv
// ID-stage issue bundle between the decoder and the hazard scoreboard.
// The decoder (master) presents one decoded instruction per cycle; the
// scoreboard (slave) answers with the stall decision and its status.
interface hazard_scoreboard_if #(
    parameter int REG_ADDR_W  = 4,
    parameter int NUM_SRC     = 3,
    parameter int STALL_CNT_W = 16
);
    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    logic                          issue_valid;
    logic [NUM_SRC*REG_ADDR_W-1:0] src;
    logic [NUM_SRC-1:0]            src_valid;
    logic [REG_ADDR_W-1:0]         dest;
    logic                          dest_wb_en;
    logic                          is_load;
    logic                          is_branch;
    logic                          fwd_en;
    logic                          hazard_detected;
    logic                          issue_fire;
    logic [NUM_REGS-1:0]           pending_mask;
    logic [STALL_CNT_W-1:0]        stall_count;

    modport master (
        output issue_valid, src, src_valid, dest, dest_wb_en,
               is_load, is_branch, fwd_en,
        input  hazard_detected, issue_fire, pending_mask, stall_count
    );

    modport slave (
        input  issue_valid, src, src_valid, dest, dest_wb_en,
               is_load, is_branch, fwd_en,
        output hazard_detected, issue_fire, pending_mask, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register in-flight write tracker for the ID stage.
// Each register carries two down-counters: cycles until the register-file
// copy is readable in ID (wb) and cycles until the result can be forwarded
// (fwd). A source operand stalls ID while the relevant counter is nonzero;
// branches resolve in ID and therefore always wait for the wb counter.
// Parameter legality: ALU_FWD_LAT, LOAD_FWD_LAT <= WB_LAT and WB_LAT >= 1.
module hazard_scoreboard #(
    parameter int REG_ADDR_W   = 4,
    parameter int NUM_SRC      = 3,
    parameter int WB_LAT       = 3,
    parameter int ALU_FWD_LAT  = 0,
    parameter int LOAD_FWD_LAT = 1,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    hazard_scoreboard_if.slave  bus
);
    localparam int NUM_REGS = 2 ** REG_ADDR_W;
    localparam int CNT_W    = $clog2(WB_LAT + 1);

    localparam logic [CNT_W-1:0] WB_LOAD_VAL   = CNT_W'(WB_LAT);
    localparam logic [CNT_W-1:0] ALU_FWD_VAL   = CNT_W'(ALU_FWD_LAT);
    localparam logic [CNT_W-1:0] LOAD_FWD_VAL  = CNT_W'(LOAD_FWD_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

    logic [CNT_W-1:0]       wb_cnt_q  [NUM_REGS];
    logic [CNT_W-1:0]       wb_cnt_d  [NUM_REGS];
    logic [CNT_W-1:0]       fwd_cnt_q [NUM_REGS];
    logic [CNT_W-1:0]       fwd_cnt_d [NUM_REGS];
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic [STALL_CNT_W-1:0] stall_cnt_d;

    logic                   hazard;
    logic                   fire;
    logic [NUM_REGS-1:0]    pending;

    // Hazard decision: any enabled source whose producer is still in flight.
    // The current instruction's own dest is deliberately not consulted.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.src_valid[i]) begin
                if (!bus.fwd_en || bus.is_branch) begin
                    if (wb_cnt_q[bus.src[i*REG_ADDR_W +: REG_ADDR_W]] != '0)
                        hazard = 1'b1;
                end else begin
                    if (fwd_cnt_q[bus.src[i*REG_ADDR_W +: REG_ADDR_W]] != '0)
                        hazard = 1'b1;
                end
            end
        end
        hazard = hazard & bus.issue_valid;
        fire   = bus.issue_valid & ~hazard;
    end

    // Next counter values: age every entry, then let a firing write reload its dest.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            wb_cnt_d[r]  = (wb_cnt_q[r]  != '0) ? wb_cnt_q[r]  - CNT_ONE : '0;
            fwd_cnt_d[r] = (fwd_cnt_q[r] != '0) ? fwd_cnt_q[r] - CNT_ONE : '0;
        end
        if (fire && bus.dest_wb_en) begin
            wb_cnt_d[bus.dest]  = WB_LOAD_VAL;
            fwd_cnt_d[bus.dest] = bus.is_load ? LOAD_FWD_VAL : ALU_FWD_VAL;
        end
    end

    // Saturating performance counter of stalled cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end

    // State registers; reset drops every in-flight entry and wins over issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                wb_cnt_q[r]  <= '0;
                fwd_cnt_q[r] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                wb_cnt_q[r]  <= wb_cnt_d[r];
                fwd_cnt_q[r] <= fwd_cnt_d[r];
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Pending view: a register is pending until its ID-readable copy lands.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++)
            pending[r] = (wb_cnt_q[r] != '0);
    end

    assign bus.hazard_detected = hazard;
    assign bus.issue_fire      = fire;
    assign bus.pending_mask    = pending;
    assign bus.stall_count     = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed instruction sequences, a cycle-time
// reference model (each register remembers the cycle its value becomes
// readable / forwardable) compared every cycle, plus literal spot checks.
// A second instance with a 2-bit stall counter shares the same stimulus.
module tb_hazard_scoreboard;
    localparam int RAW  = 4;
    localparam int NS   = 3;
    localparam int WB   = 3;
    localparam int AF   = 0;
    localparam int LF   = 1;
    localparam int SCW  = 16;
    localparam int SCW2 = 2;
    localparam int NR   = 2 ** RAW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_ADDR_W(RAW), .NUM_SRC(NS), .STALL_CNT_W(SCW))  bus   ();
    hazard_scoreboard_if #(.REG_ADDR_W(RAW), .NUM_SRC(NS), .STALL_CNT_W(SCW2)) bus_s ();

    assign bus_s.issue_valid = bus.issue_valid;
    assign bus_s.src         = bus.src;
    assign bus_s.src_valid   = bus.src_valid;
    assign bus_s.dest        = bus.dest;
    assign bus_s.dest_wb_en  = bus.dest_wb_en;
    assign bus_s.is_load     = bus.is_load;
    assign bus_s.is_branch   = bus.is_branch;
    assign bus_s.fwd_en      = bus.fwd_en;

    hazard_scoreboard #(.REG_ADDR_W(RAW), .NUM_SRC(NS), .WB_LAT(WB),
        .ALU_FWD_LAT(AF), .LOAD_FWD_LAT(LF), .STALL_CNT_W(SCW))
        u_dut (.clk(clk), .rst(rst), .bus(bus));

    hazard_scoreboard #(.REG_ADDR_W(RAW), .NUM_SRC(NS), .WB_LAT(WB),
        .ALU_FWD_LAT(AF), .LOAD_FWD_LAT(LF), .STALL_CNT_W(SCW2))
        u_sat (.clk(clk), .rst(rst), .bus(bus_s));

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                      nm, act, act, exp, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int cyc = 0;
    int wb_rdy  [NR];
    int fwd_rdy [NR];
    int sc_m  = 0;
    int sc2_m = 0;
    bit model_live = 1'b0;

    function automatic bit m_hazard();
        bit h = 1'b0;
        int s;
        if (bus.issue_valid) begin
            for (int i = 0; i < NS; i++) begin
                if (bus.src_valid[i]) begin
                    s = int'(bus.src[i*RAW +: RAW]);
                    if (!bus.fwd_en || bus.is_branch) h = h | (cyc < wb_rdy[s]);
                    else                              h = h | (cyc < fwd_rdy[s]);
                end
            end
        end
        return h;
    endfunction

    function automatic logic [NR-1:0] m_pending();
        logic [NR-1:0] p;
        for (int r = 0; r < NR; r++) p[r] = (cyc < wb_rdy[r]);
        return p;
    endfunction

    initial begin
        bit h;
        for (int r = 0; r < NR; r++) begin
            wb_rdy[r]  = 0;
            fwd_rdy[r] = 0;
        end
        forever begin
            @(negedge clk);
            if (model_live) begin
                h = m_hazard();
                chk("model_hazard",  32'(bus.hazard_detected), 32'(h));
                chk("model_fire",    32'(bus.issue_fire),      32'(bus.issue_valid & ~h));
                chk("model_pending", 32'(bus.pending_mask),    32'(m_pending()));
                chk("model_stall",   32'(bus.stall_count),     32'(sc_m));
                chk("model_stall2",  32'(bus_s.stall_count),   32'(sc2_m));
            end
            @(posedge clk);
            if (rst) begin
                for (int r = 0; r < NR; r++) begin
                    wb_rdy[r]  = 0;
                    fwd_rdy[r] = 0;
                end
                sc_m  = 0;
                sc2_m = 0;
                model_live = 1'b1;
            end else if (model_live) begin
                h = m_hazard();
                if (bus.issue_valid && !h && bus.dest_wb_en) begin
                    wb_rdy[int'(bus.dest)]  = cyc + WB + 1;
                    fwd_rdy[int'(bus.dest)] = cyc + (bus.is_load ? LF : AF) + 1;
                end
                if (h) begin
                    if (sc_m  < (2 ** SCW)  - 1) sc_m++;
                    if (sc2_m < (2 ** SCW2) - 1) sc2_m++;
                end
            end
            cyc++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        bus.issue_valid = 1'b0;
        bus.src         = '0;
        bus.src_valid   = '0;
        bus.dest        = '0;
        bus.dest_wb_en  = 1'b0;
        bus.is_load     = 1'b0;
        bus.is_branch   = 1'b0;
    endtask

    task automatic instr(input logic [RAW-1:0] d, input bit wb, input bit ld, input bit br,
                         input logic [RAW-1:0] s0, input logic [RAW-1:0] s1,
                         input logic [RAW-1:0] s2, input logic [NS-1:0] sv);
        bus.issue_valid = 1'b1;
        bus.dest        = d;
        bus.dest_wb_en  = wb;
        bus.is_load     = ld;
        bus.is_branch   = br;
        bus.src         = {s2, s1, s0};
        bus.src_valid   = sv;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        idle();
        repeat (n) next();
    endtask

    // Hold the presented instruction until it fires; returns stalled cycles.
    task automatic run_until_fire(input string nm, input int max, output int stalls);
        bit fired = 1'b0;
        stalls = 0;
        for (int k = 0; k < max && !fired; k++) begin
            mid();
            if (bus.issue_fire) fired = 1'b1;
            else stalls++;
            next();
        end
        idle();
        if (!fired) chk({nm, "_fire_timeout"}, 32'(0), 32'(1));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int st;
        rst = 1'b1;
        bus.fwd_en = 1'b1;
        idle();
        next();
        next();
        rst = 1'b0;

        // reset state, issue of a no-op
        instr(4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 3'b000);
        mid();
        chk("rst_pending", 32'(bus.pending_mask), 32'(0));
        chk("rst_hazard",  32'(bus.hazard_detected), 32'(0));
        chk("rst_fire",    32'(bus.issue_fire), 32'(1));
        chk("rst_stall",   32'(bus.stall_count), 32'(0));
        next();

        // load-use with forwarding
        instr(4'd2, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 3'b000);
        mid();
        chk("ldr_fire", 32'(bus.issue_fire), 32'(1));
        next();
        instr(4'd3, 1'b1, 1'b0, 1'b0, 4'd2, 4'd1, 4'd0, 3'b011);
        mid();
        chk("lu_hazard_c1", 32'(bus.hazard_detected), 32'(1));
        next();
        mid();
        chk("lu_hazard_c2", 32'(bus.hazard_detected), 32'(0));
        chk("lu_fire_c2",   32'(bus.issue_fire), 32'(1));
        chk("lu_stall_cnt", 32'(bus.stall_count), 32'(1));
        next();
        drain(5);

        // ALU-use with forwarding
        instr(4'd4, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 3'b000);
        next();
        instr(4'd5, 1'b1, 1'b0, 1'b0, 4'd4, 4'd4, 4'd0, 3'b011);
        mid();
        chk("au_hazard", 32'(bus.hazard_detected), 32'(0));
        chk("au_pend_c1", 32'(bus.pending_mask[4]), 32'(1));
        next();
        idle();
        mid();
        chk("au_pend_c2", 32'(bus.pending_mask[4]), 32'(1));
        next();
        mid();
        chk("au_pend_c3", 32'(bus.pending_mask[4]), 32'(1));
        next();
        mid();
        chk("au_pend_c4", 32'(bus.pending_mask[4]), 32'(0));
        next();
        drain(4);

        // forwarding off
        bus.fwd_en = 1'b0;
        instr(4'd4, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 3'b000);
        next();
        instr(4'd5, 1'b1, 1'b0, 1'b0, 4'd4, 4'd4, 4'd0, 3'b011);
        run_until_fire("nofwd", 10, st);
        chk("nofwd_stalls", 32'(st), 32'(3));
        mid();
        chk("nofwd_stall_cnt", 32'(bus.stall_count), 32'(4));
        next();
        drain(4);
        bus.fwd_en = 1'b1;

        // branch consumer ignores forwarding
        instr(4'd6, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 3'b000);
        next();
        instr(4'd0, 1'b0, 1'b0, 1'b1, 4'd6, 4'd0, 4'd0, 3'b001);
        run_until_fire("br", 10, st);
        chk("br_stalls", 32'(st), 32'(3));
        mid();
        chk("br_stall_cnt", 32'(bus.stall_count), 32'(7));
        next();
        drain(4);

        // masked operand and self-dependency
        bus.fwd_en = 1'b0;
        instr(4'd8, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 3'b000);
        next();
        instr(4'd9, 1'b1, 1'b0, 1'b0, 4'd8, 4'd8, 4'd0, 3'b100);
        mid();
        chk("mask_hazard", 32'(bus.hazard_detected), 32'(0));
        next();
        drain(4);
        instr(4'd7, 1'b1, 1'b0, 1'b0, 4'd7, 4'd0, 4'd0, 3'b001);
        mid();
        chk("self_hazard", 32'(bus.hazard_detected), 32'(0));
        next();
        idle();
        mid();
        chk("self_pend7", 32'(bus.pending_mask[7]), 32'(1));
        next();
        drain(4);

        // fwd_en toggles with immediate effect
        instr(4'd10, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 3'b000);
        next();
        instr(4'd11, 1'b1, 1'b0, 1'b0, 4'd10, 4'd0, 4'd0, 3'b001);
        mid();
        chk("tog_hazard_off", 32'(bus.hazard_detected), 32'(1));
        next();
        bus.fwd_en = 1'b1;
        mid();
        chk("tog_hazard_on", 32'(bus.hazard_detected), 32'(0));
        next();
        drain(4);

        // reset while R2 pending
        bus.fwd_en = 1'b0;
        instr(4'd2, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 3'b000);
        next();
        idle();
        rst = 1'b1;
        next();
        rst = 1'b0;
        instr(4'd3, 1'b1, 1'b0, 1'b0, 4'd2, 4'd0, 4'd0, 3'b001);
        mid();
        chk("mrst_pending", 32'(bus.pending_mask), 32'(0));
        chk("mrst_fire",    32'(bus.issue_fire), 32'(1));
        chk("mrst_stall",   32'(bus.stall_count), 32'(0));
        next();
        drain(4);

        // reset beats a same-cycle issue
        instr(4'd9, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 3'b000);
        rst = 1'b1;
        next();
        rst = 1'b0;
        idle();
        mid();
        chk("rst_vs_issue", 32'(bus.pending_mask), 32'(0));
        next();

        // stall counter saturation on the 2-bit instance
        instr(4'd4, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 3'b000);
        next();
        instr(4'd5, 1'b1, 1'b0, 1'b0, 4'd4, 4'd0, 4'd0, 3'b001);
        run_until_fire("sat1", 10, st);
        mid();
        chk("sat_first3", 32'(bus_s.stall_count), 32'(3));
        next();
        instr(4'd2, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 3'b000);
        next();
        instr(4'd3, 1'b1, 1'b0, 1'b0, 4'd2, 4'd0, 4'd0, 3'b001);
        run_until_fire("sat2", 10, st);
        chk("sat_stalls", 32'(st), 32'(3));
        mid();
        chk("sat_hold",  32'(bus_s.stall_count), 32'(3));
        chk("sat_wide",  32'(bus.stall_count),   32'(6));
        next();
        drain(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
